stage2_index_fetch: RTL and testbench

// - Second pipeline stage of the PPU memory-index path. Directly consumes stage1 outputs (index_addr[12:2], fifo_write).
// - Detects each new index address and issues one read to the synchronous index RAM.
// - Pairs each returned word with its address and buffers the pair in an output FIFO with a valid/ready handshake.
// - Credit-based issue ensures the FIFO never overflows. Superseded (never-issued) addresses are counted.

---
 rtl/stage2_index_fetch.sv | 129 ++++++++++++
 tb/tb_stage2_index_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage2_index_fetch.sv
// Stage 2 of the PPU memory-index path: dedups stage1 word indices, reads the index RAM
// and queues {addr, data} pairs in a show-ahead FIFO guarded by credit-based issue.
module stage2_index_fetch #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   core_sp_clk_i,
    input  logic                   rst_ni,
    input  logic [10:0]            index_addr_i,
    input  logic                   fifo_write_i,
    output logic                   idx_rd_en_o,
    output logic [10:0]            idx_rd_addr_o,
    input  logic [DATA_W-1:0]      idx_rd_data_i,
    output logic                   out_valid_o,
    output logic [10:0]            out_addr_o,
    output logic [DATA_W-1:0]      out_data_o,
    input  logic                   out_ready_i,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic [CNT_W-1:0]       overflow_cnt_o
);
    localparam int unsigned PtrW  = $clog2(DEPTH);
    localparam int unsigned UsedW = PtrW + 2;

    logic              have_last_q, have_last_d;
    logic [10:0]       last_addr_q, last_addr_d;
    logic              pending_q, pending_d;
    logic [10:0]       pend_addr_q, pend_addr_d;
    logic              rd_en_q, rd_en_d;
    logic [10:0]       rd_addr_q, rd_addr_d;
    logic              ret_q;
    logic [10:0]       ret_addr_q;
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [PtrW:0]     level_q, level_d;
    logic [CNT_W-1:0]  ovf_q, ovf_d;
    logic [10:0]       mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic             new_req;
    logic             issue;
    logic             push;
    logic             pop;
    logic             supersede;
    logic [UsedW-1:0] used;

    always_comb begin
        new_req   = fifo_write_i && (!have_last_q || (index_addr_i != last_addr_q));
        // Credit covers FIFO entries plus reads still travelling through the RAM.
        used      = UsedW'(level_q) + UsedW'(rd_en_q) + UsedW'(ret_q);
        issue     = pending_q && (used < UsedW'(DEPTH));
        push      = ret_q;
        pop       = (level_q != '0) && out_ready_i;
        supersede = new_req && pending_q && !issue;

        have_last_d = have_last_q;
        last_addr_d = last_addr_q;
        pending_d   = pending_q;
        pend_addr_d = pend_addr_q;
        if (new_req) begin
            have_last_d = 1'b1;
            last_addr_d = index_addr_i;
            pending_d   = 1'b1;
            pend_addr_d = index_addr_i;
        end else if (issue) begin
            pending_d = 1'b0;
        end

        rd_en_d   = issue;
        rd_addr_d = issue ? pend_addr_q : rd_addr_q;

        ovf_d  = (supersede && !(&ovf_q)) ? ovf_q + 1'b1 : ovf_q;

        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge core_sp_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            have_last_q <= 1'b0;
            last_addr_q <= '0;
            pending_q   <= 1'b0;
            pend_addr_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            ret_q       <= 1'b0;
            ret_addr_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            ovf_q       <= '0;
        end else begin
            have_last_q <= have_last_d;
            last_addr_q <= last_addr_d;
            pending_q   <= pending_d;
            pend_addr_q <= pend_addr_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            ret_q       <= rd_en_q;
            ret_addr_q  <= rd_addr_q;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge core_sp_clk_i) begin
        if (push) begin
            mem_addr_q[wptr_q] <= ret_addr_q;
            mem_data_q[wptr_q] <= idx_rd_data_i;
        end
    end

    assign idx_rd_en_o    = rd_en_q;
    assign idx_rd_addr_o  = rd_addr_q;
    assign out_valid_o    = (level_q != '0);
    assign out_addr_o     = out_valid_o ? mem_addr_q[rptr_q] : '0;
    assign out_data_o     = out_valid_o ? mem_data_q[rptr_q] : '0;
    assign fifo_level_o   = level_q;
    assign overflow_cnt_o = ovf_q;

endmodule

// File: tb/tb_stage2_index_fetch.sv
// Scoreboard bench for stage2_index_fetch: a queue-based reference model predicts every
// RAM read and FIFO output; a negedge monitor compares the DUT against it each cycle.
module tb_stage2_index_fetch;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [10:0]       index_addr = '0;
    logic              fifo_write = 1'b0;
    logic              out_ready = 1'b0;
    logic              rd_en, rd_en4, ov, ov4;
    logic [10:0]       rd_addr, rd_addr4, oa, oa4;
    logic [DATA_W-1:0] ram_q = '0, ram4_q = '0, od, od4;
    logic [3:0]        lvl, lvl4;
    logic [15:0]       ovf;
    logic [3:0]        ovf4;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;

    always #5 clk = ~clk;

    stage2_index_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .core_sp_clk_i(clk), .rst_ni(rst_n), .index_addr_i(index_addr),
        .fifo_write_i(fifo_write), .idx_rd_en_o(rd_en), .idx_rd_addr_o(rd_addr),
        .idx_rd_data_i(ram_q), .out_valid_o(ov), .out_addr_o(oa), .out_data_o(od),
        .out_ready_i(out_ready), .fifo_level_o(lvl), .overflow_cnt_o(ovf)
    );

    stage2_index_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .core_sp_clk_i(clk), .rst_ni(rst_n), .index_addr_i(index_addr),
        .fifo_write_i(fifo_write), .idx_rd_en_o(rd_en4), .idx_rd_addr_o(rd_addr4),
        .idx_rd_data_i(ram4_q), .out_valid_o(ov4), .out_addr_o(oa4), .out_data_o(od4),
        .out_ready_i(out_ready), .fifo_level_o(lvl4), .overflow_cnt_o(ovf4)
    );

    function automatic logic [31:0] ramf(input logic [10:0] a);
        return {5'h15, a, 5'h0a, ~a};
    endfunction

    // Synchronous index RAMs: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en)  ram_q  <= ramf(rd_addr);
        if (rd_en4) ram4_q <= ramf(rd_addr4);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct packed {
        logic [10:0] addr;
        logic [31:0] data;
    } item_t;

    bit          m_have_last = 0;
    bit          m_pending = 0;
    logic [10:0] m_last = '0;
    logic [10:0] m_pend = '0;
    logic [10:0] m_fifo[$];
    logic [10:0] m_oq_addr[$];
    int          m_due[$];
    bit          m_rd_en = 0;
    logic [10:0] m_rd_addr = '0;
    int          m_ovf = 0;
    item_t       sb[$];
    bit          prev_valid = 0;
    logic [10:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    task automatic model_reset();
        m_have_last = 0;
        m_pending   = 0;
        m_fifo.delete();
        m_oq_addr.delete();
        m_due.delete();
        m_rd_en     = 0;
        m_ovf       = 0;
        sb.delete();
        prev_valid  = 0;
    endtask

    // One clock edge of the reference, using the inputs present at that edge.
    task automatic model_step();
        bit nr, iss;
        nr  = fifo_write && (!m_have_last || index_addr != m_last);
        iss = m_pending && ((m_fifo.size() + m_oq_addr.size()) < DEPTH);
        if (out_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
        foreach (m_due[i]) m_due[i]--;
        while (m_due.size() > 0 && m_due[0] == 0) begin
            m_fifo.push_back(m_oq_addr.pop_front());
            void'(m_due.pop_front());
        end
        m_rd_en = iss;
        if (iss) begin
            m_rd_addr = m_pend;
            m_oq_addr.push_back(m_pend);
            m_due.push_back(2);
            sb.push_back({m_pend, ramf(m_pend)});
        end
        if (nr) begin
            if (m_pending && !iss) m_ovf++;
            m_pend      = index_addr;
            m_pending   = 1;
            m_last      = index_addr;
            m_have_last = 1;
        end else if (iss) begin
            m_pending = 0;
        end
    endtask

    // Monitor: inputs change at negedge+1, so at negedge they still equal the values
    // sampled at the preceding posedge.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (prev_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_empty: got accepted addr 0x%0h, expected no output",
                                 prev_addr);
                    end else begin
                        e = sb.pop_front();
                        chk("out_addr", 64'(prev_addr), 64'(e.addr));
                        chk("out_data", 64'(prev_data), 64'(e.data));
                    end
                end
                model_step();
                chk("idx_rd_en", 64'(rd_en), 64'(m_rd_en));
                if (m_rd_en) chk("idx_rd_addr", 64'(rd_addr), 64'(m_rd_addr));
                chk("idx_rd_en4", 64'(rd_en4), 64'(m_rd_en));
                chk("fifo_level", 64'(lvl), 64'(m_fifo.size()));
                chk("fifo_level4", 64'(lvl4), 64'(m_fifo.size()));
                chk("out_valid", 64'(ov), 64'(m_fifo.size() > 0));
                chk("overflow_cnt", 64'(ovf), 64'(m_ovf > 65535 ? 65535 : m_ovf));
                chk("overflow_cnt4", 64'(ovf4), 64'(m_ovf > 15 ? 15 : m_ovf));
                if (rd_en) rd_cnt++;
                prev_valid = ov;
                prev_addr  = oa;
                prev_data  = od;
            end
        end
    end

    task automatic drive(input bit fw, input logic [10:0] a, input bit rdy);
        @(negedge clk);
        #1;
        fifo_write = fw;
        index_addr = a;
        out_ready  = rdy;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 11'h0, rdy);
    endtask

    // Caller positions time; checks async clear, holds reset, releases at negedge+1.
    task automatic do_reset();
        rst_n      = 1'b0;
        fifo_write = 1'b0;
        out_ready  = 1'b0;
        #1;
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_out_addr", 64'(oa), 64'd0);
        chk("rst_out_data", 64'(od), 64'd0);
        chk("rst_level", 64'(lvl), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst4_rd_en", 64'(rd_en4), 64'd0);
        chk("rst4_rd_addr", 64'(rd_addr4), 64'd0);
        chk("rst4_out", 64'({ov4, oa4, od4}), 64'd0);
        chk("rst4_level_ovf", 64'({lvl4, ovf4}), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, lat;
        #1;
        do_reset();

        // Held address: one read, output 4 cycles after the first sample
        base = rd_cnt;
        drive(1'b1, 11'h005, 1'b1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ov && lat == 0) lat = i;
        end
        chk("latency", 64'(lat), 64'd4);
        chk("held_reads", 64'(rd_cnt - base), 64'd1);

        // Consecutive distinct addresses, no backpressure
        base = rd_cnt;
        drive(1'b1, 11'h001, 1'b1);
        drive(1'b1, 11'h002, 1'b1);
        drive(1'b1, 11'h003, 1'b1);
        idle(8, 1'b1);
        chk("seq_reads", 64'(rd_cnt - base), 64'd3);
        chk("seq_ovf", 64'(ovf), 64'd0);

        // Backpressure: 12 addresses, only 8 fit, last 3 supersede the 9th
        base = rd_cnt;
        for (int i = 0; i < 12; i++) drive(1'b1, 11'h100 + 11'(i), 1'b0);
        idle(10, 1'b0);
        chk("full_level", 64'(lvl), 64'd8);
        chk("full_reads", 64'(rd_cnt - base), 64'd8);
        chk("full_ovf", 64'(ovf), 64'd3);

        // Single pop frees one credit for the waiting address
        base = rd_cnt;
        drive(1'b0, 11'h0, 1'b1);
        idle(6, 1'b0);
        chk("refill_level", 64'(lvl), 64'd8);
        chk("refill_reads", 64'(rd_cnt - base), 64'd1);
        idle(12, 1'b1);

        // Reset with three entries queued and one read in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 11'h200 + 11'(i), 1'b0);
        idle(4, 1'b0);
        drive(1'b1, 11'h203, 1'b0);
        drive(1'b0, 11'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_rd_en", 64'(rd_en), 64'd1);
        chk("pre_rst_level", 64'(lvl), 64'd3);
        #1;
        do_reset();
        base = rd_cnt;
        drive(1'b1, 11'h203, 1'b1);
        idle(8, 1'b1);
        chk("refetch_reads", 64'(rd_cnt - base), 64'd1);

        // Randomized traffic with a mid-run reset
        for (int i = 0; i < 500; i++) begin
            if (i == 250) begin
                @(negedge clk);
                #1;
                do_reset();
            end
            drive($urandom_range(0, 9) < 7, 11'h300 + 11'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
        end
        idle(20, 1'b1);

        // Saturation: 40 distinct addresses while stalled -> 31 supersedes
        @(negedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 40; i++) drive(1'b1, 11'h400 + 11'(i), 1'b0);
        idle(6, 1'b0);
        chk("sat_ovf16", 64'(ovf), 64'd31);
        chk("sat_ovf4", 64'(ovf4), 64'd15);
        idle(20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
